// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM encoding, the burst counter width and grant width helper.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;

  function automatic int gnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping around past the top index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GNT_W = gnt_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GNT_W-1:0] ptr_i,
  output logic             any_o,
  output logic [GNT_W-1:0] pick_o
);

  int idx;

  always_comb begin
    any_o  = |req_i;
    pick_o = '0;
    idx    = 0;
    // Walk offsets high-to-low so the nearest request wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(ptr_i) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx[GNT_W-1:0]]) pick_o = idx[GNT_W-1:0];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async FIFO write port among
// N_REQ requesters; bursts shorten while the FIFO is half full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_LINES     = 8,
  parameter int MAX_BURST      = 8,
  parameter int THROTTLE_BURST = 2,
  localparam int GNT_W         = gnt_w(N_REQ)
) (
  input  logic                        wclk,
  input  logic                        wrst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_LINES-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        wfull,
  input  logic                        half_full,
  output logic                        winc,
  output logic [DATA_LINES-1:0]       wdata,
  output logic [GNT_W-1:0]            gnt_id,
  output logic                        busy
);

  arb_state_e       state_q, state_d;
  logic [GNT_W-1:0] rr_q, rr_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_req;
  logic [GNT_W-1:0] pick;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] cnt_inc;
  logic             room;
  logic             beat;
  logic [GNT_W-1:0] nxt_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .GNT_W (GNT_W)
  ) u_pick (
    .req_i  (req_valid),
    .ptr_i  (rr_q),
    .any_o  (any_req),
    .pick_o (pick)
  );

  assign limit   = half_full ? CNT_W'(THROTTLE_BURST)
                             : CNT_W'(MAX_BURST);
  assign cnt_inc = cnt_q + 1'b1;
  // No beat once the live limit is already used up.
  assign room    = cnt_q < limit;
  assign nxt_ptr = (gnt_q == GNT_W'(N_REQ - 1)) ? '0
                                                : gnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    winc      = 1'b0;
    wdata     = '0;
    beat      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready[gnt_q] = !wfull && room;
        beat  = req_valid[gnt_q] && !wfull && room;
        winc  = beat;
        wdata = req_data[gnt_q*DATA_LINES +: DATA_LINES];
        if (beat) begin
          cnt_d = cnt_inc;
          if (req_last[gnt_q] || cnt_inc >= limit) begin
            rr_d    = nxt_ptr;
            state_d = IDLE;
          end
        end else if (!room || (!wfull && !req_valid[gnt_q])) begin
          rr_d    = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_id = gnt_q;
  assign busy   = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a burst-level reference
// model tracking owner, beats granted and the round-robin pointer.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int MAX = 8;
  localparam int THR = 2;
  localparam int GW  = 2;

  logic              wclk = 1'b0;
  logic              wrst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              wfull;
  logic              half_full;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic [GW-1:0]     gnt_id;
  logic              busy;

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(
    .N_REQ          (N),
    .DATA_LINES     (DW),
    .MAX_BURST      (MAX),
    .THROTTLE_BURST (THR)
  ) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wfull     (wfull),
    .half_full (half_full),
    .winc      (winc),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit m_busy;
  int m_own;
  int m_ptr;
  int m_beats;

  // Observed burst lengths in the first phase
  int  run_beats;
  int  bursts_seen;

  task automatic model_reset();
    m_busy  = 0;
    m_own   = 0;
    m_ptr   = 0;
    m_beats = 0;
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(99) < p;
  endfunction

  task automatic run_phase(input int cycles, input int p_v,
                           input int p_l, input int p_f,
                           input int p_h, input int p_r);
    int lim;
    bit can;
    bit e_winc;
    logic [N-1:0] e_rdy;
    logic [DW-1:0] e_data;
    for (int c = 0; c < cycles; c++) begin
      @(negedge wclk);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = pct(p_v);
        req_last[i]  = pct(p_l);
      end
      req_data = $urandom;
      wfull    = pct(p_f);
      if (pct(p_h)) half_full = ~half_full;
      wrst     = pct(p_r);
      #1;
      lim    = half_full ? THR : MAX;
      can    = m_busy && (m_beats < lim);
      e_winc = can && req_valid[m_own] && !wfull;
      e_rdy  = '0;
      e_data = '0;
      if (m_busy) begin
        if (can && !wfull) e_rdy[m_own] = 1'b1;
        e_data = req_data[m_own*DW +: DW];
      end
      check("busy", 32'(busy), 32'(m_busy));
      check("gnt_id", 32'(gnt_id), 32'(m_own));
      check("winc", 32'(winc), 32'(e_winc));
      check("ready", 32'(req_ready), 32'(e_rdy));
      if (e_winc) check("wdata", 32'(wdata), 32'(e_data));
      if (wfull) check("no_winc_full", 32'(winc), 32'd0);
      @(posedge wclk);
      if (wrst) begin
        model_reset();
      end else if (!m_busy) begin
        for (int k = N - 1; k >= 0; k--)
          if (req_valid[(m_ptr + k) % N]) begin
            m_own  = (m_ptr + k) % N;
            m_busy = 1;
          end
        m_beats = 0;
      end else begin
        if (e_winc) m_beats++;
        if ((e_winc && (req_last[m_own] || m_beats >= lim)) ||
            (!e_winc && (!can || (!wfull && !req_valid[m_own])))) begin
          if (p_v == 100 && p_l == 0 && p_f == 0 && p_h == 0) begin
            check("burst_len", 32'(m_beats), 32'(MAX));
            bursts_seen++;
          end
          m_ptr  = (m_own + 1) % N;
          m_busy = 0;
        end
      end
    end
  endtask

  initial begin
    run_beats   = 0;
    bursts_seen = 0;
    wrst      = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    wfull     = 1'b0;
    half_full = 1'b0;
    repeat (2) @(posedge wclk);
    model_reset();
    @(negedge wclk);
    wrst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_winc", 32'(winc), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_gnt", 32'(gnt_id), 32'd0);
    // Saturated round-robin, full-length bursts
    run_phase(200, 100, 0, 0, 0, 0);
    check("rr_bursts_seen", 32'(bursts_seen >= 15), 32'd1);
    // Sparse requesters with end-of-burst markers
    run_phase(600, 40, 20, 0, 0, 0);
    // FIFO back-pressure stalls
    run_phase(600, 95, 5, 25, 0, 0);
    // Throttling via slow half_full toggling
    run_phase(600, 95, 5, 5, 6, 0);
    // Requesters dropping valid mid-burst
    run_phase(600, 70, 10, 10, 10, 0);
    // Occasional reset mid-traffic
    run_phase(600, 90, 10, 10, 10, 3);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
